// File: rtl/step_ctrl_pkg.sv
// Shared state encodings for the clock-enable scheduler and the LED/display logic.
package step_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_STEP = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

endpackage

// File: rtl/step_ctrl_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, counter debouncer and a
// registered one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DEB_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    logic [1:0]       r_sync;
    logic [DEB_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_btn};
            r_stable_d <= r_stable;
            r_rise     <= r_stable & ~r_stable_d;
            // Flip only after 2^DEB_W consecutive disagreeing samples.
            if (r_sync[1] != r_stable) begin
                if (r_cnt == '1) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/step_ctrl.sv
// Clock-enable scheduler: run-mode divider or debounced single-step issue, with halt.
// Optional step counter on `ce` pulses is built when STEP_CNT_EN is defined.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = 28,
    parameter int unsigned DEB_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               halt_req,
    output logic               ce,
    output logic [STATE_W-1:0] state,
    output logic [15:0]        step_cnt
);

    logic             r_run_meta;
    logic             r_run_s;
    logic             w_btn_rise;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_ce;
    logic             w_ce_nxt;

    btn_debounce #(
        .DEB_W (DEB_W)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (step_btn),
        .o_rise (w_btn_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
        end else begin
            r_run_meta <= run_sw;
            r_run_s    <= r_run_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_STEP;
            r_div   <= '0;
            r_ce    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_ce    <= w_ce_nxt;
        end
    end

    // Divider defaults to 0, so it is held cleared outside S_RUN and on every exit.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        w_ce_nxt    = 1'b0;
        if (halt_req) begin
            w_state_nxt = S_HALT;
        end else begin
            case (r_state)
                S_STEP: begin
                    if (w_btn_rise) w_ce_nxt = 1'b1;
                    if (r_run_s)    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!r_run_s) begin
                        w_state_nxt = S_STEP;
                    end else if (r_div == '1) begin
                        w_ce_nxt = 1'b1;
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
                S_HALT: begin
                    if (w_btn_rise && !r_run_s) w_state_nxt = S_STEP;
                end
                default: w_state_nxt = S_STEP;
            endcase
        end
    end

    assign ce    = r_ce;
    assign state = r_state;

`ifdef STEP_CNT_EN
    logic [15:0] r_step_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
        end else if (r_ce) begin
            r_step_cnt <= r_step_cnt + 16'd1;
        end
    end

    assign step_cnt = r_step_cnt;
`else
    assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: stimulus queues expected ce cycles, a negedge monitor pops them.
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_sw;
    logic        step_btn;
    logic        halt_req;
    logic        ce;
    logic [1:0]  state;
    logic [15:0] step_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_exp  = 0;
    int mon_exp;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_ctrl #(
        .DIV_W (4),
        .DEB_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .ce       (ce),
        .state    (state),
        .step_cnt (step_cnt)
    );

    always @(negedge clk) begin
        if (ce === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ce_unexpected: ce high at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_exp != cyc) begin
                    errors++;
                    $display("FAIL ce_timing: ce at cycle %0d, expected cycle %0d", cyc, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_sc();
`ifdef STEP_CNT_EN
        return n_exp;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit bounce, input bit expect_ce);
        if (bounce) begin
            for (int k = 0; k < 10; k++) begin
                step_btn = (k % 2 == 0);
                tick(1);
            end
        end
        step_btn = 1'b1;
        if (expect_ce) begin
            exp_q.push_back(cyc + 20);
            n_exp++;
        end
        tick(40);
        step_btn = 1'b0;
        tick(30);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int k0;
        rst_n    = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt_req = 1'b0;
        tick(3);
        chk("reset_ce", ce, 0);
        chk("reset_state", state, 0);
        chk("reset_step_cnt", step_cnt, 0);
        rst_n = 1'b1;
        tick(50);
        chk("idle_state", state, 0);
        chk("idle_step_cnt", step_cnt, 0);

        // Run mode: S_RUN three edges after the switch, then ce every 16 cycles.
        k0 = cyc;
        run_sw = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(k0 + 19 + 16 * i);
        n_exp += 5;
        tick(4);
        chk("run_state", state, 1);
        wait_to(k0 + 84);
        chk("run_step_cnt", step_cnt, exp_sc());

        // Halt raised while the divider holds 15: the sixth pulse must not appear.
        wait_to(k0 + 98);
        halt_req = 1'b1;
        tick(1);
        chk("halt_state", state, 2);
        chk("halt_ce", ce, 0);
        tick(3);
        halt_req = 1'b0;
        tick(100);
        chk("halt_hold_state", state, 2);

        press(1'b0, 1'b0);
        chk("halt_press_run_state", state, 2);
        run_sw = 1'b0;
        tick(5);
        press(1'b0, 1'b0);
        chk("halt_release_state", state, 0);
        press(1'b1, 1'b1);
        chk("step_state", state, 0);
        chk("step_step_cnt", step_cnt, exp_sc());

        halt_req = 1'b1;
        tick(2);
        chk("halt2_state", state, 2);
        press(1'b0, 1'b0);
        chk("halt2_press_state", state, 2);
        halt_req = 1'b0;
        press(1'b0, 1'b0);
        chk("halt2_release_state", state, 0);

        // Reset asserted while a run-mode ce is high.
        k0 = cyc;
        run_sw = 1'b1;
        exp_q.push_back(k0 + 19);
        n_exp++;
        wait_to(k0 + 19);
        @(negedge clk);
        #1;
        chk("pre_reset_ce", ce, 1);
        rst_n = 1'b0;
        n_exp = 0;
        #1;
        chk("async_reset_ce", ce, 0);
        chk("async_reset_state", state, 0);
        chk("async_reset_step_cnt", step_cnt, 0);
        tick(2);
        run_sw = 1'b0;
        rst_n  = 1'b1;
        tick(5);
        chk("post_reset_state", state, 0);
        chk("post_reset_step_cnt", step_cnt, exp_sc());

        chk("ce_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
